// File: rtl/bit_packer_if.sv
// Field-in / word-out bus of the bit packer.
// The producer/consumer side uses the master modport and the packer uses the slave modport.
interface bit_packer_if;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flush;
    logic        reqin;
    logic        full;
    logic        pushout;
    logic [31:0] dataout;

    modport master (
        output pushin, lenin, datain, flush, reqin,
        input  full, pushout, dataout
    );

    modport slave (
        input  pushin, lenin, datain, flush, reqin,
        output full, pushout, dataout
    );
endinterface

// File: rtl/bit_packer.sv
// Bit packer: packs 0..15-bit fields MSB-first into 32-bit words.
// Completed words are buffered in a small word FIFO.
// A consumer drains the FIFO one word per reqin, and each granted request gives a one-cycle pushout.
module bit_packer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         clock,
    input  logic         reset,
    bit_packer_if.slave  bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // The accumulator holds cnt_q pending bits, right-justified; the oldest bit is the highest valid bit.
    logic [46:0]   acc_q, acc_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          pushout_q, pushout_d;
    logic [31:0]   dataout_q, dataout_d;

    logic [31:0]   mem [DEPTH];

    logic          wr_en;
    logic [31:0]   wr_word;
    logic          rd_en;
    logic          full_w;
    logic [46:0]   masked;
    logic [46:0]   wide;
    logic [46:0]   shifted;
    logic [46:0]   flushed;
    logic [5:0]    new_cnt;
    logic [5:0]    rem;

    assign full_w = (occ_q == DEPTH_C);

    // Packing: append the masked field, and split off a full word when 32 or more bits are pending.
    always_comb begin
        masked  = {32'd0, bus.datain} & ((47'd1 << bus.lenin) - 47'd1);
        wide    = (acc_q << bus.lenin) | masked;
        new_cnt = cnt_q + {2'b00, bus.lenin};
        rem     = new_cnt - 6'd32;
        shifted = wide >> rem;
        flushed = acc_q << (6'd32 - cnt_q);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_word = 32'd0;
        if (!full_w) begin
            if (bus.pushin) begin
                if (new_cnt >= 6'd32) begin
                    wr_en   = 1'b1;
                    wr_word = shifted[31:0];
                    acc_d   = wide & ((47'd1 << rem) - 47'd1);
                    cnt_d   = rem;
                end else begin
                    acc_d = wide;
                    cnt_d = new_cnt;
                end
            end else if (bus.flush && (cnt_q != 6'd0)) begin
                // Left-align the partial bits at word bit 31 and zero-pad the remaining bits.
                wr_en   = 1'b1;
                wr_word = flushed[31:0];
                acc_d   = 47'd0;
                cnt_d   = 6'd0;
            end
        end
    end

    // FIFO bookkeeping: serve a read only if the FIFO was non-empty before the edge.
    always_comb begin
        rd_en     = bus.reqin && (occ_q != '0);
        wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d     = occ_q;
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        pushout_d = rd_en;
        dataout_d = rd_en ? mem[rd_ptr_q] : 32'd0;
    end

    // Word storage; the pointers and occupancy counter define what is valid, so this array has no reset.
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    // State registers, with a synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            pushout_q <= 1'b0;
            dataout_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            pushout_q <= pushout_d;
            dataout_q <= dataout_d;
        end
    end

    assign bus.full    = full_w;
    assign bus.pushout = pushout_q;
    assign bus.dataout = dataout_q;
endmodule

// File: tb/tb_bit_packer.sv
// Testbench for bit_packer: directed cases plus randomized traffic.
// A bit-queue reference model feeds a scoreboard, and a negedge monitor checks the DUT outputs.
module tb_bit_packer;
    localparam int DEPTH = 8;

    logic clock;
    logic reset;
    bit_packer_if bus();

    bit_packer #(.DEPTH(DEPTH), .AW(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the pending bits as a queue, and the buffered words as a queue.
    bit          bitq[$];
    logic [31:0] mfifo[$];
    logic [31:0] expq[$];

    int          tests;
    int          fails;
    int          out_count;
    logic [31:0] last_out;
    bit          mon_en;

    function automatic logic [31:0] take_word();
        logic [31:0] w;
        for (int i = 31; i >= 0; i--) w[i] = bitq.pop_front();
        return w;
    endfunction

    // Apply the current inputs across one rising edge and update the model as the specification dictates.
    task automatic tick();
        logic        p, f, r, rs;
        logic [3:0]  l;
        logic [14:0] d;
        bit          was_full;
        p = bus.pushin; f = bus.flush; r = bus.reqin; l = bus.lenin; d = bus.datain; rs = reset;
        @(posedge clock);
        if (!rs) begin
            bitq.delete();
            mfifo.delete();
        end else begin
            was_full = (mfifo.size() == DEPTH);
            if (r && mfifo.size() > 0) expq.push_back(mfifo.pop_front());
            if (!was_full) begin
                if (p) begin
                    for (int i = int'(l) - 1; i >= 0; i--) bitq.push_back(d[i]);
                    if (bitq.size() >= 32) mfifo.push_back(take_word());
                end else if (f && bitq.size() > 0) begin
                    while (bitq.size() < 32) bitq.push_back(1'b0);
                    mfifo.push_back(take_word());
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.pushin = 0; bus.flush = 0; bus.reqin = 0; bus.lenin = 0; bus.datain = 0;
    endtask

    task automatic push(input int len, input int val);
        bus.pushin = 1; bus.lenin = 4'(len); bus.datain = 15'(val);
        tick();
        idle();
    endtask

    task automatic do_flush();
        bus.flush = 1;
        tick();
        idle();
    endtask

    task automatic req_expect(input string name, input logic [31:0] exp);
        int c0;
        c0 = out_count;
        bus.reqin = 1;
        tick();
        idle();
        @(negedge clock);
        #1;
        tests++;
        if (out_count != c0 + 1 || last_out !== exp) begin
            fails++;
            $display("FAIL %s: got word %08h (words seen %0d), expected %08h (words %0d)",
                     name, last_out, out_count - c0, exp, 1);
        end
    endtask

    task automatic req_none(input string name);
        int c0;
        c0 = out_count;
        bus.reqin = 1;
        tick();
        idle();
        @(negedge clock);
        #1;
        tests++;
        if (out_count != c0) begin
            fails++;
            $display("FAIL %s: got %0d words, expected 0", name, out_count - c0);
        end
    endtask

    task automatic check_full(input string name, input logic exp);
        tests++;
        if (bus.full !== exp) begin
            fails++;
            $display("FAIL %s: full=%b, expected %b", name, bus.full, exp);
        end
    endtask

    // Monitor: check the full flag every cycle, and pop the scoreboard whenever a word should appear.
    always @(negedge clock) begin
        if (mon_en) begin
            tests++;
            if (bus.full !== (mfifo.size() == DEPTH)) begin
                fails++;
                $display("FAIL full_flag: full=%b, expected %b", bus.full, (mfifo.size() == DEPTH));
            end
            tests++;
            if (bus.pushout === 1'b1) begin
                out_count++;
                last_out = bus.dataout;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_pushout: got dataout %08h, expected no word", bus.dataout);
                end else begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    if (bus.dataout !== e) begin
                        fails++;
                        $display("FAIL word_data: got %08h, expected %08h", bus.dataout, e);
                    end else begin
                        $display("[TB] word %0d: %08h", out_count, bus.dataout);
                    end
                end
            end else if (expq.size() > 0) begin
                logic [31:0] e;
                e = expq.pop_front();
                fails++;
                $display("FAIL missing_pushout: got pushout=%b, expected word %08h", bus.pushout, e);
            end else if (bus.pushout !== 1'b0 || bus.dataout !== 32'd0) begin
                fails++;
                $display("FAIL idle_output: got pushout=%b dataout=%08h, expected 0/00000000",
                         bus.pushout, bus.dataout);
            end
        end
    end

    initial begin
        tests = 0; fails = 0; out_count = 0; last_out = 0; mon_en = 0;
        idle();
        reset = 0;
        tick(); tick();
        reset = 1;
        mon_en = 1;
        check_full("reset_full", 1'b0);

        // 1. Exact-word packing
        push(15, 'h7FFF); push(15, 'h0000); push(2, 'h3);
        req_expect("exact_word", 32'hFFFE0003);
        req_none("empty_after_exact");

        // 2. Masking and flush
        push(3, 'h7FFD);
        do_flush();
        req_expect("mask_flush", 32'hA0000000);
        do_flush();
        req_none("flush_cnt0");

        // 3. Word-boundary crossing
        push(15, 'h7FFF); push(15, 'h7FFF); push(15, 'h7FFF);
        do_flush();
        req_expect("cross_w0", 32'hFFFFFFFF);
        req_expect("cross_w1", 32'hFFF80000);

        // 4. Full and backpressure
        for (int i = 0; i < 32; i++) push(8, i);
        check_full("full_set", 1'b1);
        push(8, 'hFF);
        do_flush();
        check_full("full_hold", 1'b1);
        req_expect("full_oldest", 32'h00010203);
        check_full("full_drop", 1'b0);
        for (int i = 1; i < 8; i++) req_expect("full_drain", {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
        do_flush();
        req_none("ignored_push_lost");

        // 5. Concurrent read/write with pointer wrap; pushin+flush acts as push only
        bus.reqin = 1;
        for (int i = 0; i < 43; i++) begin
            bus.pushin = 1; bus.lenin = 4'd15; bus.datain = 15'($urandom);
            bus.flush = (i % 5 == 0);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin bus.reqin = 1; tick(); end
        idle();

        // 6. Reset mid-operation with cnt=9 and three words buffered
        do_flush();
        for (int i = 0; i < 6; i++) begin bus.reqin = 1; tick(); end
        idle();
        for (int i = 0; i < 7; i++) push(15, $urandom);
        reset = 0;
        tick();
        reset = 1;
        check_full("reset_mid_full", 1'b0);
        req_none("reset_mid_empty");
        push(4, 'hA);
        do_flush();
        req_expect("reset_fresh", 32'hA0000000);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.pushin = ($urandom_range(0, 9) < 6);
            bus.lenin  = 4'($urandom_range(0, 15));
            bus.datain = 15'($urandom);
            bus.flush  = ($urandom_range(0, 9) == 0);
            bus.reqin  = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 5 : 2));
            tick();
        end
        idle();
        do_flush();
        for (int i = 0; i < DEPTH + 4; i++) begin bus.reqin = 1; tick(); end
        idle();
        tick(); tick();
        tests++;
        if (expq.size() != 0 || mfifo.size() != 0) begin
            fails++;
            $display("FAIL final_drain: got %0d pending, expected 0", expq.size() + mfifo.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
